dsp_addsub_rr_sched: RTL and testbench
======================================

Name: dsp_addsub_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined 48-bit add/sub DSP datapath (the ADDSUB_MACRO, LATENCY 0-2) between NREQ requesters.
- Accepts operand/opcode packets over per-requester valid/ready handshakes, issues at most one operation per cycle to the datapath, and tracks requester IDs through a tag pipeline matched to the datapath latency.
- Routes each result back to its originator with a one-hot response strobe.
- Also sequences the datapath's synchronous reset after system reset.

Parameters:
- NREQ, 4, number of requesters (2-8).
- WIDTH, 48, operand/result width (1-48); must match the datapath WIDTH.
- LATENCY, 2, datapath latency in cycles (0-2); must match the datapath LATENCY.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- REQ_VALID  in  NREQ  per-requester request valid
- REQ_READY  out  NREQ  per-requester grant/accept, one-hot or zero
- REQ_A  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- REQ_B  in  NREQ*WIDTH  operand B, same packing as REQ_A
- REQ_ADD_SUB  in  NREQ  1 = add, 0 = subtract
- REQ_CARRYIN  in  NREQ  carry-in per requester
- RSP_VALID  out  NREQ  one-hot result strobe, one cycle
- RSP_RESULT  out  WIDTH  result, valid when any RSP_VALID bit is high
- RSP_CARRYOUT  out  1  carry-out, valid with RSP_RESULT
- BUSY  out  1  high while the issue register or any tag stage is valid
- DSP_A  out  WIDTH  to datapath A
- DSP_B  out  WIDTH  to datapath B
- DSP_ADD_SUB  out  1  to datapath ADD_SUB
- DSP_CARRYIN  out  1  to datapath CARRYIN
- DSP_CE  out  1  to datapath CE
- DSP_RST  out  1  to datapath RST (synchronous)
- DSP_RESULT  in  WIDTH  from datapath RESULT
- DSP_CARRYOUT  in  1  from datapath CARRYOUT

Behaviour:

Reset values (while RST = 1):
- REQ_READY = 0, RSP_VALID = 0, BUSY = 0.
- DSP_A = 0, DSP_B = 0, DSP_ADD_SUB = 1, DSP_CARRYIN = 0.
- DSP_CE = 1, DSP_RST = 1.
- Priority pointer = 0, issue/tag valids = 0, state = FLUSH, flush counter = 0.

State machine:
- FLUSH: DSP_RST = 1, DSP_CE = 1, REQ_READY = 0. Lasts max(LATENCY,1) cycles after RST deasserts, then goes to RUN.
- RUN: DSP_RST = 0, DSP_CE = 1. Stays in RUN until RST.
- RST asserted mid-operation: async return to FLUSH. All in-flight tags are cleared and no RSP_VALID is produced for them. Requesters must re-present their packets.

Arbitration (RUN only, combinational):
- Grant the lowest index j ≥ pointer (mod NREQ) with REQ_VALID[j] = 1. REQ_READY = onehot(j).
- Transfer happens when REQ_VALID[j] & REQ_READY[j]. Pointer then becomes (j+1) mod NREQ.
- No transfer means the pointer is held.
- Requesters hold VALID and the payload stable until READY. A requester may deassert VALID before it is granted.

Issue and tag pipeline:
- On transfer in cycle t, the selected operands, opcode and carry-in are registered onto DSP_* at t+1.
- The issue tag {valid, id} enters a LATENCY-deep shift register.
- If no transfer occurs, the issue tag valid = 0 and the DSP_* operands hold their last values.

Response:
- RSP_VALID[id] = 1 in cycle t+1+LATENCY for the tag transferred at t. For LATENCY = 0 this is cycle t+1.
- RSP_RESULT = DSP_RESULT and RSP_CARRYOUT = DSP_CARRYOUT, passed through combinationally.
- There is no response backpressure; requesters must sink results.
- Throughput is one operation per cycle. Back-to-back grants to the same requester are allowed when it is the only one requesting.

Arithmetic:
- Performed entirely by the datapath: add → A+B+CARRYIN; sub → A−B−CARRYIN per the macro's convention.
- Results are WIDTH bits with wrap-around; overflow is visible only through CARRYOUT.

Test Plan:
1. Reset release, WIDTH=48, LATENCY=2, no requests → DSP_RST = 1 for 2 cycles after RST falls, REQ_READY = 0 during FLUSH, then RUN with BUSY = 0 and RSP_VALID = 0.
2. Requester 2 only: A=100, B=23, add, carry-in 0 at cycle t → REQ_READY = 0b0100 at t; RSP_VALID = 0b0100 at t+3 with RSP_RESULT = 123 and RSP_CARRYOUT = 0.
3. All four requesters continuously valid, each with a distinct subtract (e.g. A=i*10, B=i) → grant order 0,1,2,3,0,1 on consecutive cycles; responses 0,9,18,27 arrive on consecutive cycles in the same order 3 cycles later.
4. Requester 1 issues add 0xFFFF_FFFF_FFFF + 1 with carry-in 0 → RSP_RESULT = 0 and RSP_CARRYOUT = 1 (wrap-around).
5. Requesters 0 and 3 valid with pointer = 1 → requester 3 is granted first, then requester 0, and the pointer ends at 1.
6. Three operations in flight, then RST pulsed for 1 cycle → no RSP_VALID for the flushed operations, DSP_RST reasserted for 2 cycles, and a new request after FLUSH completes correctly.

Source files
------------

// File: rtl/dsp_addsub_rr_sched_if.sv
// Bundle for requester, response and datapath traffic of the shared add/sub scheduler.
// master: the environment (requesters plus the add/sub datapath).
// slave:  the scheduler itself.
interface dsp_addsub_rr_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 48
);
    // Requester side
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_add_sub;
    logic [NREQ-1:0]       req_carryin;

    // Response side
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_carryout;
    logic                  busy;

    // Datapath side
    logic [WIDTH-1:0]      dsp_a;
    logic [WIDTH-1:0]      dsp_b;
    logic                  dsp_add_sub;
    logic                  dsp_carryin;
    logic                  dsp_ce;
    logic                  dsp_rst;
    logic [WIDTH-1:0]      dsp_result;
    logic                  dsp_carryout;

    modport master (
        output req_valid, req_a, req_b, req_add_sub, req_carryin,
        output dsp_result, dsp_carryout,
        input  req_ready, rsp_valid, rsp_result, rsp_carryout, busy,
        input  dsp_a, dsp_b, dsp_add_sub, dsp_carryin, dsp_ce, dsp_rst
    );

    modport slave (
        input  req_valid, req_a, req_b, req_add_sub, req_carryin,
        input  dsp_result, dsp_carryout,
        output req_ready, rsp_valid, rsp_result, rsp_carryout, busy,
        output dsp_a, dsp_b, dsp_add_sub, dsp_carryin, dsp_ce, dsp_rst
    );
endinterface

// File: rtl/dsp_addsub_rr_sched.sv
// Round-robin scheduler sharing one pipelined add/sub datapath between NREQ requesters.
// Requester IDs ride a tag pipeline matched to the datapath latency so each result is
// steered back to its originator. The datapath's synchronous reset is held for
// max(LATENCY,1) cycles after system reset so no stale pipeline contents escape.
module dsp_addsub_rr_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned LATENCY = 2
) (
    input logic                  clk,
    input logic                  rst,
    dsp_addsub_rr_sched_if.slave bus
);
    localparam int unsigned IdW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned FlushLen = (LATENCY > 0) ? LATENCY : 1;

    typedef logic [IdW-1:0] id_t;

    typedef enum logic [0:0] {
        StFlush,
        StRun
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;

    logic       arb_en;
    logic       dsp_rst;

    logic [NREQ-1:0] grant;
    logic            grant_any;
    id_t             grant_id;
    id_t             ptr_q;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_add_sub;
    logic             sel_carryin;

    logic [WIDTH-1:0] dsp_a_q;
    logic [WIDTH-1:0] dsp_b_q;
    logic             dsp_add_sub_q;
    logic             dsp_carryin_q;
    logic             issue_vld_q;
    id_t              issue_id_q;

    logic             rsp_vld;
    id_t              rsp_id;
    logic             tag_any;

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------

    // State register with flush cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state: leave FLUSH once the datapath has been reset for FlushLen cycles
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            StFlush: begin
                if (flush_cnt_q == 2'(FlushLen - 1)) begin
                    state_d     = StRun;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StFlush;
        endcase
    end

    // Outputs: arbitration only in RUN, datapath reset only in FLUSH
    always_comb begin
        arb_en  = 1'b0;
        dsp_rst = 1'b1;
        case (state_q)
            StRun: begin
                arb_en  = 1'b1;
                dsp_rst = 1'b0;
            end
            default: begin
                arb_en  = 1'b0;
                dsp_rst = 1'b1;
            end
        endcase
    end

    assign bus.dsp_rst = dsp_rst;
    assign bus.dsp_ce  = 1'b1;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------

    // Search upward from the pointer, wrapping, for the first valid requester
    always_comb begin
        int  idx;
        id_t cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            cand = id_t'(idx);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        if (!arb_en) begin
            grant_any = 1'b0;
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            grant[i] = grant_any && (grant_id == id_t'(i));
        end
    end

    // grant is only ever raised on a valid requester, so grant_any marks a transfer
    assign bus.req_ready = grant;

    // Pointer moves just past the winner on a transfer, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (grant_id == id_t'(NREQ - 1)) ? '0 : grant_id + id_t'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------------

    // Operand mux for the granted requester
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        sel_add_sub = 1'b1;
        sel_carryin = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_id == id_t'(i)) begin
                sel_a       = bus.req_a[i*WIDTH +: WIDTH];
                sel_b       = bus.req_b[i*WIDTH +: WIDTH];
                sel_add_sub = bus.req_add_sub[i];
                sel_carryin = bus.req_carryin[i];
            end
        end
    end

    // Register the winner onto the datapath; operands hold when nothing transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_a_q       <= '0;
            dsp_b_q       <= '0;
            dsp_add_sub_q <= 1'b1;
            dsp_carryin_q <= 1'b0;
            issue_vld_q   <= 1'b0;
            issue_id_q    <= '0;
        end else begin
            issue_vld_q <= grant_any;
            if (grant_any) begin
                dsp_a_q       <= sel_a;
                dsp_b_q       <= sel_b;
                dsp_add_sub_q <= sel_add_sub;
                dsp_carryin_q <= sel_carryin;
                issue_id_q    <= grant_id;
            end
        end
    end

    assign bus.dsp_a       = dsp_a_q;
    assign bus.dsp_b       = dsp_b_q;
    assign bus.dsp_add_sub = dsp_add_sub_q;
    assign bus.dsp_carryin = dsp_carryin_q;

    // ------------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------------

    if (LATENCY == 0) begin : g_no_tag
        // Combinational datapath: result lines up with the issue register
        assign rsp_vld = issue_vld_q;
        assign rsp_id  = issue_id_q;
        assign tag_any = 1'b0;
    end else begin : g_tag
        logic [LATENCY-1:0] tag_vld_q;
        id_t                tag_id_q [LATENCY];

        // Shift {valid, id} alongside the datapath stages
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_vld_q <= '0;
                for (int k = 0; k < int'(LATENCY); k++) begin
                    tag_id_q[k] <= '0;
                end
            end else begin
                tag_vld_q[0] <= issue_vld_q;
                tag_id_q[0]  <= issue_id_q;
                for (int k = 1; k < int'(LATENCY); k++) begin
                    tag_vld_q[k] <= tag_vld_q[k-1];
                    tag_id_q[k]  <= tag_id_q[k-1];
                end
            end
        end

        assign rsp_vld = tag_vld_q[LATENCY-1];
        assign rsp_id  = tag_id_q[LATENCY-1];
        assign tag_any = |tag_vld_q;
    end

    // ------------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------------

    // One-hot strobe back to the originating requester
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.rsp_valid[i] = rsp_vld && (rsp_id == id_t'(i));
        end
    end

    assign bus.rsp_result   = bus.dsp_result;
    assign bus.rsp_carryout = bus.dsp_carryout;
    assign bus.busy         = issue_vld_q | tag_any;

endmodule

// File: tb/tb_dsp_addsub_rr_sched.sv
// Bench for dsp_addsub_rr_sched: a latency-2 add/sub datapath model sits behind the DUT,
// a transaction-level model predicts every output each cycle, and directed tests pin
// hand-computed values.
module tb_dsp_addsub_rr_sched;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned WIDTH    = 48;
    localparam int unsigned LATENCY  = 2;
    localparam int          FlushLen = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dsp_addsub_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dsp_addsub_rr_sched #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {carry, result} of the datapath operation
    function automatic logic [WIDTH:0] arith(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic add, input logic cin);
        logic [WIDTH:0] c;
        c = {{WIDTH{1'b0}}, cin};
        if (add) return {1'b0, a} + {1'b0, b} + c;
        else     return {1'b0, a} - {1'b0, b} - c;
    endfunction

    // Datapath model: two register stages, synchronous reset, clock enable
    logic [WIDTH:0] dp_s1, dp_s2;
    always @(posedge clk) begin
        if (bus.dsp_rst) begin
            dp_s1 <= '0;
            dp_s2 <= '0;
        end else if (bus.dsp_ce) begin
            dp_s1 <= arith(bus.dsp_a, bus.dsp_b, bus.dsp_add_sub, bus.dsp_carryin);
            dp_s2 <= dp_s1;
        end
    end
    assign bus.dsp_result   = dp_s2[WIDTH-1:0];
    assign bus.dsp_carryout = dp_s2[WIDTH];

    // Clock edges seen since reset release
    int post_rel = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) post_rel <= 0;
        else if (post_rel < 1000) post_rel <= post_rel + 1;
    end

    // ------------------------------------------------------------------------
    // Transaction model and per-cycle compare
    // ------------------------------------------------------------------------
    typedef struct {
        int             due;
        int             id;
        logic [WIDTH:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   m_ptr = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic             m_as = 1'b1;
    logic             m_ci = 1'b0;
    int               m_g;
    logic [NREQ-1:0]  m_rdy;
    logic [NREQ-1:0]  m_rsp;
    logic [WIDTH:0]   m_val;
    logic             m_busy;

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(p + k) % int'(NREQ)]) return (p + k) % int'(NREQ);
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("m_rst_req_ready", bus.req_ready, 0);
            check("m_rst_rsp_valid", bus.rsp_valid, 0);
            check("m_rst_busy", bus.busy, 0);
            check("m_rst_dsp_rst", bus.dsp_rst, 1);
            check("m_rst_dsp_ce", bus.dsp_ce, 1);
            check("m_rst_dsp_a", bus.dsp_a, 0);
            check("m_rst_dsp_b", bus.dsp_b, 0);
            check("m_rst_dsp_add_sub", bus.dsp_add_sub, 1);
            check("m_rst_dsp_carryin", bus.dsp_carryin, 0);
            q.delete();
            m_ptr = 0;
            m_a   = '0;
            m_b   = '0;
            m_as  = 1'b1;
            m_ci  = 1'b0;
        end else begin
            m_g   = (post_rel >= FlushLen) ? model_grant(bus.req_valid, m_ptr) : -1;
            m_rdy = '0;
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            m_rsp  = '0;
            m_val  = '0;
            m_busy = 1'b0;
            foreach (q[i]) begin
                if (q[i].due == cyc) begin
                    m_rsp[q[i].id] = 1'b1;
                    m_val          = q[i].val;
                end
                if (q[i].due - int'(LATENCY) <= cyc && cyc <= q[i].due) m_busy = 1'b1;
            end
            check("m_dsp_rst", bus.dsp_rst, (post_rel >= FlushLen) ? 0 : 1);
            check("m_dsp_ce", bus.dsp_ce, 1);
            check("m_req_ready", bus.req_ready, m_rdy);
            check("m_rsp_valid", bus.rsp_valid, m_rsp);
            check("m_busy", bus.busy, m_busy);
            check("m_dsp_a", bus.dsp_a, m_a);
            check("m_dsp_b", bus.dsp_b, m_b);
            check("m_dsp_ops", {bus.dsp_add_sub, bus.dsp_carryin}, {m_as, m_ci});
            if (m_rsp != 0) begin
                check("m_rsp_result", bus.rsp_result, m_val[WIDTH-1:0]);
                check("m_rsp_carryout", bus.rsp_carryout, m_val[WIDTH]);
            end
            if (m_g >= 0) begin
                m_a  = bus.req_a[m_g*WIDTH +: WIDTH];
                m_b  = bus.req_b[m_g*WIDTH +: WIDTH];
                m_as = bus.req_add_sub[m_g];
                m_ci = bus.req_carryin[m_g];
                q.push_back('{due: cyc + 1 + int'(LATENCY), id: m_g,
                              val: arith(m_a, m_b, m_as, m_ci)});
                m_ptr = (m_g + 1) % int'(NREQ);
            end
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic add, input logic cin);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_add_sub[i]          = add;
        bus.req_carryin[i]          = cin;
        bus.req_valid[i]            = 1'b1;
    endtask

    task automatic issue_one(input string name, input int i, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic add, input logic cin,
                             input logic [63:0] exp_res, input logic exp_co);
        @(posedge clk); #1;
        set_req(i, a, b, add, cin);
        @(negedge clk);
        check({name, "_grant"}, bus.req_ready, 64'd1 << i);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        repeat (LATENCY + 1) @(negedge clk);
        check({name, "_rsp_valid"}, bus.rsp_valid, 64'd1 << i);
        check({name, "_result"}, bus.rsp_result, exp_res);
        check({name, "_carryout"}, bus.rsp_carryout, exp_co);
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_add_sub = '0;
        bus.req_carryin = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dsp_rst", bus.dsp_rst, 1);
        check("reset_dsp_add_sub", bus.dsp_add_sub, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_req_ready", bus.req_ready, 0);

        // Release: two FLUSH cycles, then RUN and idle
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush0_dsp_rst", bus.dsp_rst, 1);
        @(negedge clk);
        check("flush1_dsp_rst", bus.dsp_rst, 1);
        @(negedge clk);
        check("run_dsp_rst", bus.dsp_rst, 0);
        check("run_idle_busy", bus.busy, 0);
        check("run_idle_rsp", bus.rsp_valid, 0);

        // All four requesting: grants 0,1,2,3,0,1; results 9*i three cycles later
        @(posedge clk); #1;
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 48'(i * 10), 48'(i), 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 6) check("rr_grant", bus.req_ready, 64'd1 << (k % 4));
            if (k >= 3) begin
                check("rr_rsp_valid", bus.rsp_valid, 64'd1 << ((k - 3) % 4));
                check("rr_rsp_result", bus.rsp_result, 64'(9 * ((k - 3) % 4)));
            end
            if (k == 5) begin
                @(posedge clk); #1;
                bus.req_valid = '0;
            end
        end

        // Single requester add, subtract with borrow, wrap-around, add with carry-in
        issue_one("req2_add", 2, 48'd100, 48'd23, 1'b1, 1'b0, 64'd123, 1'b0);
        issue_one("req3_sub_borrow", 3, 48'd5, 48'd7, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFE, 1'b1);
        issue_one("req1_wrap", 1, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b1, 1'b0, 64'd0, 1'b1);
        issue_one("req0_add_cin", 0, 48'd5, 48'd6, 1'b1, 1'b1, 64'd12, 1'b0);

        // Pointer at 1 with requesters 0 and 3: 3 wins, then 0, pointer back at 1
        @(posedge clk); #1;
        set_req(0, 48'd1, 48'd1, 1'b1, 1'b0);
        set_req(3, 48'd2, 48'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("ptr_first_grant", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        check("ptr_second_grant", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        set_req(1, 48'd3, 48'd3, 1'b1, 1'b0);
        set_req(2, 48'd4, 48'd4, 1'b1, 1'b0);
        @(negedge clk);
        check("ptr_probe_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("ptr_probe_next", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        repeat (5) @(negedge clk);

        // Three ops in flight, then a one-cycle reset pulse flushes them
        @(posedge clk); #1;
        set_req(0, 48'd11, 48'd1, 1'b1, 1'b0);
        set_req(1, 48'd22, 48'd2, 1'b1, 1'b0);
        set_req(2, 48'd33, 48'd3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_pre_grant", bus.req_ready, 64'd1 << k);
            @(posedge clk); #1;
            bus.req_valid[k] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("pulse_busy", bus.busy, 0);
        check("pulse_rsp", bus.rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("flushed_no_rsp", bus.rsp_valid, 0);
            check("reflush_dsp_rst", bus.dsp_rst, (k < FlushLen) ? 1 : 0);
        end
        issue_one("post_reset", 2, 48'd7, 48'd8, 1'b1, 1'b0, 64'd15, 1'b0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
